// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I core.
// Sequences the shared datapath registers (PC, IR, OldPC, Data, A/B, ALUOut)
// through their write enables and mux/ALU selects. One unified memory serves
// both fetch and data access; memory states wait on the mem_ready handshake.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   opcode, funct3, funct7b5  instruction fields from the IR
//   zero            ALU zero flag (branch resolution)
//   mem_ready       memory completes the current access this cycle
//   pc_write, ir_write, mem_write, reg_write   register/memory write enables
//   adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src  selects
//   mem_timeout     one-cycle pulse when a memory wait is aborted
//   state           current state encoding (debug)
//   illegal_instr   high while trapped (only with MULTICYCLE_CTRL_TRAP_EN)
//
// Parameters:
//   WAIT_LIMIT  max cycles to wait for mem_ready (0 = wait forever)
//   CNT_W       wait counter width (WAIT_LIMIT < 2**CNT_W)
//
// Build option: define MULTICYCLE_CTRL_TRAP_EN to trap on unrecognised opcodes.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       mem_timeout,
  output logic [3:0] state
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;
  logic             timeout;
  logic [2:0]       funct_alu;

  always_comb begin
    funct_alu = 3'b000;
    case (funct3)
      3'b000:  funct_alu = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign waiting = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign timeout = (WAIT_LIMIT != 0) && waiting && (cnt_q == CNT_W'(WAIT_LIMIT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    mem_timeout = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
        state_d     = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero;
        state_d     = FETCH;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      TRAP:    state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase

    // Counter only advances while stalled in place; any exit clears it.
    if (waiting && !mem_ready && !timeout) cnt_d = cnt_q + CNT_W'(1);

    // An expired wait aborts the access: no enable may fire for it.
    if (timeout) begin
      state_d     = FETCH;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      mem_timeout = 1'b1;
    end

    if (!rst) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign illegal_instr = (state_q == TRAP);
`endif

endmodule
